// File: rtl/conv1d_pkg.sv
// Shared types and width helper for the weight-stationary 1-D convolution row.
package conv1d_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2
  } state_t;

  // Default accumulator width: full product plus growth for K additions plus sign guard.
  function automatic int unsigned acc_w(input int unsigned dw, input int unsigned k);
    return 2 * dw + $clog2(k) + 1;
  endfunction

endpackage

// File: rtl/conv1d_systolic_row_if.sv
// Weight-load, activation-in and psum-out handshake bundle for conv1d_systolic_row.
interface conv1d_systolic_row_if
  import conv1d_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ACC_WIDTH  = acc_w(8, 3)
);

  logic                         w_valid;
  logic signed [DATA_WIDTH-1:0] w_data;
  logic                         w_ready;

  logic                         valid_in;
  logic signed [DATA_WIDTH-1:0] data_in;
  logic                         frame_start;
  logic                         ready_in;

  logic                         valid_out;
  logic                         ready_out;
  logic signed [ACC_WIDTH-1:0]  psum_out;
  logic                         weights_ok;

  modport master (
    output w_valid, w_data, valid_in, data_in, frame_start, ready_out,
    input  w_ready, ready_in, valid_out, psum_out, weights_ok
  );

  modport slave (
    input  w_valid, w_data, valid_in, data_in, frame_start, ready_out,
    output w_ready, ready_in, valid_out, psum_out, weights_ok
  );

endinterface

// File: rtl/conv_pe.sv
// One transposed-form tap: stationary weight, signed multiply, add downstream psum, psum register.
module conv_pe #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ACC_WIDTH  = 19
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         w_load,
  input  logic signed [DATA_WIDTH-1:0] w_data,
  input  logic                         en,
  input  logic                         clear,
  input  logic signed [DATA_WIDTH-1:0] x,
  input  logic signed [ACC_WIDTH-1:0]  psum_in,
  output logic signed [ACC_WIDTH-1:0]  psum_out
);

  localparam int unsigned PW = 2 * DATA_WIDTH;
  localparam int unsigned XW = ACC_WIDTH - PW;

  logic signed [DATA_WIDTH-1:0] w_q;
  logic signed [PW-1:0]         prod;
  logic signed [ACC_WIDTH-1:0]  prod_ext;
  logic signed [ACC_WIDTH-1:0]  psum_d;

  always_comb begin : p_mac
    prod     = w_q * x;
    prod_ext = {{XW{prod[PW-1]}}, prod};
    psum_d   = prod_ext + (clear ? ACC_WIDTH'(0) : psum_in);
  end

  always_ff @(posedge clk or negedge rst_n) begin : p_regs
    if (!rst_n) begin
      w_q      <= '0;
      psum_out <= '0;
    end else begin
      if (w_load) w_q <= w_data;
      if (en)     psum_out <= psum_d;
    end
  end

endmodule

// File: rtl/conv1d_systolic_row.sv
// Weight-stationary 1-D convolution row, K taps in transposed form with registered psum output.
// Optional build macro CONV1D_RELU_EN clamps negative results to zero at the output register.
module conv1d_systolic_row
  import conv1d_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned KERNEL_SIZE = 3,
  parameter int unsigned ACC_WIDTH   = acc_w(DATA_WIDTH, KERNEL_SIZE)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  conv1d_systolic_row_if.slave  bus
);

  localparam int unsigned DW = DATA_WIDTH;
  localparam int unsigned AW = ACC_WIDTH;
  localparam int unsigned K  = KERNEL_SIZE;
  localparam int unsigned CW = (K > 1) ? $clog2(K) : 1;
  localparam int unsigned PW = 2 * DW;
  localparam int unsigned XW = AW - PW;
  localparam logic [CW-1:0] LAST = CW'(K - 1);

  state_t            state_q, state_d;
  logic [CW-1:0]     wcnt_q, wcnt_d;
  logic [CW-1:0]     count_q, count_d, n_eff;
  logic              weights_ok_q;
  logic              fresh_q;
  logic              valid_out_q;
  logic signed [AW-1:0] psum_q, psum_d;
  logic signed [DW-1:0] w0_q;

  logic              w_rdy, s_rdy, w_acc, s_acc, clear, produce;
  logic signed [PW-1:0] prod0;
  logic signed [AW-1:0] y;
  logic signed [AW-1:0] psum_link [K];

  // Weight port wins over activations; samples only flow once a full set is loaded.
  assign w_rdy = (state_q != RUN) || !valid_out_q;
  assign s_rdy = (state_q == RUN) && !bus.w_valid && (!valid_out_q || bus.ready_out);
  assign w_acc = bus.w_valid && w_rdy;
  assign s_acc = bus.valid_in && s_rdy;

  always_ff @(posedge clk or negedge rst_n) begin : p_fsm_q
    if (!rst_n) begin
      state_q <= EMPTY;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // Any accepted word starts or continues a load; the K-th word arms RUN.
  always_comb begin : p_fsm_d
    state_d = state_q;
    wcnt_d  = wcnt_q;
    if (w_acc) begin
      if (wcnt_q == LAST) begin
        state_d = RUN;
        wcnt_d  = '0;
      end else begin
        state_d = LOAD;
        wcnt_d  = wcnt_q + CW'(1);
      end
    end
  end

  // Tap 0 is combinational so a full-kernel sum leaves in the accepting cycle.
  always_comb begin : p_tap0
    clear   = bus.frame_start || fresh_q;
    n_eff   = clear ? '0 : count_q;
    produce = (n_eff == LAST);
    count_d = produce ? n_eff : n_eff + CW'(1);
    prod0   = w0_q * bus.data_in;
    y       = {{XW{prod0[PW-1]}}, prod0} + (clear ? AW'(0) : psum_link[0]);
`ifdef CONV1D_RELU_EN
    psum_d  = y[AW-1] ? AW'(0) : y;
`else
    psum_d  = y;
`endif
  end

  assign psum_link[K-1] = '0;

  for (genvar i = 1; i < K; i++) begin : g_tap
    conv_pe #(
      .DATA_WIDTH (DW),
      .ACC_WIDTH  (AW)
    ) u_pe (
      .clk      (clk),
      .rst_n    (rst_n),
      .w_load   (w_acc && (wcnt_q == CW'(i))),
      .w_data   (bus.w_data),
      .en       (s_acc),
      .clear    (clear),
      .x        (bus.data_in),
      .psum_in  (psum_link[i]),
      .psum_out (psum_link[i-1])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin : p_dp
    if (!rst_n) begin
      weights_ok_q <= 1'b0;
      fresh_q      <= 1'b1;
      count_q      <= '0;
      valid_out_q  <= 1'b0;
      psum_q       <= '0;
      w0_q         <= '0;
    end else begin
      weights_ok_q <= (state_d == RUN);
      if (w_acc)      fresh_q <= 1'b1;
      else if (s_acc) fresh_q <= 1'b0;
      if (w_acc && (wcnt_q == '0)) w0_q <= bus.w_data;
      if (s_acc) count_q <= count_d;
      if (s_acc && produce) begin
        valid_out_q <= 1'b1;
        psum_q      <= psum_d;
      end else if (bus.ready_out) begin
        valid_out_q <= 1'b0;
      end
    end
  end

  assign bus.w_ready    = w_rdy;
  assign bus.ready_in   = s_rdy;
  assign bus.valid_out  = valid_out_q;
  assign bus.psum_out   = psum_q;
  assign bus.weights_ok = weights_ok_q;

endmodule
